reg_writeback_queue: RTL

- Writer-side front end for the 8 x 16-bit register file. Accepts result writes from execute/memory stages through a valid/ready handshake.
- Buffers results in a small FIFO and drains one per cycle onto the register file write port (reg_write, writeReg, write_data).
- Provides forwarding lookup on two read addresses, so operand readers see pending writes before they land in the register file.

---
 rtl/reg_writeback_queue_pkg.sv | 13 +
 rtl/reg_writeback_queue_fwd_match.sv | 31 +++
 rtl/reg_writeback_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Types shared by the writeback queue, the register file and the datapath.
package reg_writeback_queue_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_fwd_match.sv
// Youngest-wins address match of one read port against all pending queue entries.
// Purely combinational; scanning from head to tail lets later (younger) hits override earlier ones.
module reg_writeback_queue_fwd_match
   import reg_writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0]           addr,
   input  wb_entry_t [DEPTH-1:0]       entries,
   input  logic [DEPTH-1:0]            valid,
   input  logic [PW-1:0]               head,
   output logic                        hit,
   output logic [DATA_W-1:0]           data
);

   always_comb begin
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (valid[idx] && (entries[idx].addr == addr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/reg_writeback_queue.sv
// Buffers register results and drains one per cycle onto the register file write port, with forwarding.
// Accept at edge N drives reg_write from cycle N+1; in_ready falls at full, wr_stall holds the head.
module reg_writeback_queue #(
   parameter int DATA_W = reg_writeback_queue_pkg::DATA_W,
   parameter int ADDR_W = reg_writeback_queue_pkg::ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_reg,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     wr_stall,
   output logic                     reg_write,
   output logic [ADDR_W-1:0]        writeReg,
   output logic [DATA_W-1:0]        write_data,
   input  logic [ADDR_W-1:0]        rd_addr1,
   input  logic [ADDR_W-1:0]        rd_addr2,
   output logic                     fwd_hit1,
   output logic [DATA_W-1:0]        fwd_data1,
   output logic                     fwd_hit2,
   output logic [DATA_W-1:0]        fwd_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   import reg_writeback_queue_pkg::wb_entry_t;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] mem;
   logic [DEPTH-1:0]      ent_valid;
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         cnt;
   logic                  push;
   logic                  pop;
   logic                  hit1;
   logic                  hit2;
   logic [DATA_W-1:0]     data1;
   logic [DATA_W-1:0]     data2;

   assign count     = cnt;
   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign in_ready  = !full && !rst;
   assign reg_write = !empty && !wr_stall && !rst;
   assign push      = in_valid && in_ready;
   assign pop       = reg_write;

   assign writeReg   = empty ? '0 : mem[head].addr;
   assign write_data = empty ? '0 : mem[head].data;

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         cnt       <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            ent_valid[tail] <= 1'b1;
            tail            <= tail + 1'b1;
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage is deliberately left out of reset; ent_valid guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{addr: in_reg, data: in_data};
      end
   end

   reg_writeback_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .addr    (rd_addr1),
      .entries (mem),
      .valid   (ent_valid),
      .head    (head),
      .hit     (hit1),
      .data    (data1)
   );

   reg_writeback_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .addr    (rd_addr2),
      .entries (mem),
      .valid   (ent_valid),
      .head    (head),
      .hit     (hit2),
      .data    (data2)
   );

   assign fwd_hit1  = hit1 && !rst;
   assign fwd_data1 = rst ? '0 : data1;
   assign fwd_hit2  = hit2 && !rst;
   assign fwd_data2 = rst ? '0 : data2;

endmodule
